// File: rtl/ms_alu_sequencer.sv
// ms_alu_sequencer: drives msALU and register-file strobes so that Rx <- f(Rx, Ry); state moves on the CLKb falling edge.
// Start->Done takes 1 cycle (LDI/MOV) or 4 cycles (ALU ops); Start is accepted only while Ready, otherwise ignored.
module ms_alu_sequencer #(
   parameter int RW   = 3,
   parameter int IW   = 3 + 2*RW + 1,
   parameter int NREG = 2**RW
) (
   input  logic            CLKb,
   input  logic            RSTb,
   input  logic [IW-1:0]   Instr,
   input  logic            Start,
   output logic            Ready,
   output logic            Done,
   output logic            IRin,
   output logic [NREG-1:0] Rin,
   output logic [NREG-1:0] Rout,
   output logic            ExtOut,
   output logic            QOut,
   output logic            Ain,
   output logic            Gin,
   output logic            Gout,
   output logic [2:0]      ALUControl
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_T1   = 3'd1;
   localparam logic [2:0] S_T2   = 3'd2;
   localparam logic [2:0] S_T3   = 3'd3;
   localparam logic [2:0] S_T4   = 3'd4;

   localparam logic [2:0] OP_MOV = 3'b110;
   localparam logic [2:0] OP_LDI = 3'b111;

   logic [2:0]      state;
   logic [2:0]      state_nxt;
   logic [IW-1:1]   ir;
   logic [2:0]      op;
   logic [RW-1:0]   rx;
   logic [RW-1:0]   ry;
   logic [NREG-1:0] rx_oh;
   logic [NREG-1:0] ry_oh;
   logic            alu_op;
   logic            unused_rsvd;

   // The reserved instruction bit is never stored, so it cannot influence anything.
   assign unused_rsvd = Instr[0];

   assign op     = ir[IW-1 -: 3];
   assign rx     = ir[IW-4 -: RW];
   assign ry     = ir[IW-4-RW -: RW];
   assign rx_oh  = NREG'(1) << rx;
   assign ry_oh  = NREG'(1) << ry;
   assign alu_op = (op != OP_MOV) && (op != OP_LDI);

   always_comb begin
      state_nxt = S_IDLE;
      case (state)
         S_IDLE:  state_nxt = Start ? S_T1 : S_IDLE;
         S_T1:    state_nxt = alu_op ? S_T2 : S_IDLE;
         S_T2:    state_nxt = S_T3;
         S_T3:    state_nxt = S_T4;
         S_T4:    state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(negedge CLKb or negedge RSTb) begin
      if (!RSTb) begin
         state <= S_IDLE;
         ir    <= '0;
      end else begin
         state <= state_nxt;
         if (state == S_IDLE && Start) begin
            ir <= Instr[IW-1:1];
         end
      end
   end

   always_comb begin
      Ready      = (state == S_IDLE);
      Done       = 1'b0;
      Rin        = '0;
      Rout       = '0;
      ExtOut     = 1'b0;
      QOut       = 1'b0;
      Ain        = 1'b0;
      Gin        = 1'b0;
      Gout       = 1'b0;
      ALUControl = 3'b000;
      case (state)
         S_T1: begin
            if (op == OP_LDI) begin
               ExtOut = 1'b1;
               Rin    = rx_oh;
               Done   = 1'b1;
            end else if (op == OP_MOV) begin
               Rout   = ry_oh;
               Rin    = rx_oh;
               Done   = 1'b1;
            end else begin
               Rout       = rx_oh;
               Ain        = 1'b1;
               ALUControl = op;
            end
         end
         S_T2: begin
            Rout       = ry_oh;
            Gin        = 1'b1;
            ALUControl = op;
         end
         S_T3: begin
            Gout       = 1'b1;
            ALUControl = op;
         end
         S_T4: begin
            QOut       = 1'b1;
            Rin        = rx_oh;
            Done       = 1'b1;
            ALUControl = op;
         end
         default: ;
      endcase
   end

   // Held low during reset so an external IR mirror never captures while the sequencer is cleared.
   assign IRin = Start && Ready && RSTb;

endmodule
